// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: FSM state encoding and ACK levels.
// Optional debug ports are enabled with I2C_TARGET_DBG_EN.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        DEV_ADDR   = 4'd1,
        DEV_ACK    = 4'd2,
        REG_ADDR   = 4'd3,
        REG_ACK    = 4'd4,
        WRITE_DATA = 4'd5,
        WRITE_ACK  = 4'd6,
        READ_DATA  = 4'd7,
        READ_ACK   = 4'd8,
        IGNORE     = 4'd9
    } i2c_target_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and bus-event detector.
// Pulses are registered, so they trail the pins by SYNC_STAGES+1 cycles.
module i2c_bus_sync
    import i2c_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Synchronize both lines, keep one cycle of history, register events.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_bit   <= I2C_NACK;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d     <= scl_now;
            sda_d     <= sda_now;
            scl_rise  <= scl_now & ~scl_d;
            scl_fall  <= ~scl_now & scl_d;
            start_det <= scl_now & scl_d & sda_d & ~sda_now;
            stop_det  <= scl_now & scl_d & ~sda_d & sda_now;
            sda_bit   <= sda_now;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C register-access target; drives SDA open-drain only.
// Define I2C_TARGET_DBG_EN to add the DBG_STATE/DBG_BITS outputs.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter int         SYS_CLK_SPEED = 50000000,
    parameter logic [6:0] TARGET_ADDR   = 7'h1D,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       GSENSOR_SCL,
    inout  wire        GSENSOR_SDA,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
`ifdef I2C_TARGET_DBG_EN
    ,
    output i2c_target_state_e DBG_STATE,
    output logic [7:0]        DBG_BITS
`endif
);

    if (SYNC_STAGES < 2 || SYS_CLK_SPEED <= 0) begin : g_param_err
        $error("i2c_target: bad SYNC_STAGES or SYS_CLK_SPEED");
    end

    i2c_target_state_e state;
    logic [3:0]        bit_cnt;
    logic [7:0]        sr;
    logic              sda_oe;
    logic              rw_q;
    logic              rd_load;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;
    logic              sda_bit;

    assign GSENSOR_SDA = sda_oe ? 1'b0 : 1'bz;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (GSENSOR_SCL),
        .sda      (GSENSOR_SDA),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_bit  (sda_bit)
    );

    // Protocol FSM: shift on SCL rise, change SDA only after SCL fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            sr        <= 8'd0;
            sda_oe    <= 1'b0;
            rw_q      <= 1'b0;
            rd_load   <= 1'b0;
            reg_addr  <= 8'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            rd_load <= reg_re;
            if (rd_load)
                sr <= reg_rdata;
            if (stop_det) begin
                state   <= IDLE;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                state   <= DEV_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    DEV_ADDR: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_bit};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (sr[7:1] == TARGET_ADDR) begin
                                state  <= DEV_ACK;
                                busy   <= 1'b1;
                                sda_oe <= 1'b1;
                                rw_q   <= sr[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_rise && rw_q) begin
                            reg_re <= 1'b1;
                        end else if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw_q) begin
                                state  <= READ_DATA;
                                sda_oe <= ~sr[7];
                            end else begin
                                state  <= REG_ADDR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    REG_ADDR: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_bit};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            reg_addr <= sr;
                            state    <= REG_ACK;
                            sda_oe   <= 1'b1;
                        end
                    end
                    REG_ACK: begin
                        if (scl_fall) begin
                            state   <= WRITE_DATA;
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                    end
                    WRITE_DATA: begin
                        if (scl_rise) begin
                            sr      <= {sr[6:0], sda_bit};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                reg_wdata <= {sr[6:0], sda_bit};
                                reg_we    <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state  <= WRITE_ACK;
                            sda_oe <= 1'b1;
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            state    <= WRITE_DATA;
                            sda_oe   <= 1'b0;
                            bit_cnt  <= 4'd0;
                            reg_addr <= reg_addr + 8'd1;
                        end
                    end
                    READ_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= READ_ACK;
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                            end else begin
                                sr     <= {sr[6:0], 1'b0};
                                sda_oe <= ~sr[6];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_bit == I2C_ACK) begin
                                reg_addr <= reg_addr + 8'd1;
                                reg_re   <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall) begin
                            state   <= READ_DATA;
                            sda_oe  <= ~sr[7];
                            bit_cnt <= 4'd0;
                        end
                    end
                    IDLE, IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef I2C_TARGET_DBG_EN
    logic start_seen;
    logic stop_seen;
    logic ack_driven;

    assign ack_driven = sda_oe & (state == DEV_ACK || state == REG_ACK ||
                                  state == WRITE_ACK);
    assign DBG_STATE  = state;
    assign DBG_BITS   = {bit_cnt, 1'b0, ack_driven, start_seen, stop_seen};

    // Remember which bus condition was seen last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_seen <= 1'b0;
            stop_seen  <= 1'b0;
        end else if (stop_det) begin
            start_seen <= 1'b0;
            stop_seen  <= 1'b1;
        end else if (start_det) begin
            start_seen <= 1'b1;
            stop_seen  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C controller bench for i2c_target with a register-file model.
// Random transactions are checked against a plain array model of the registers.
module tb_i2c_target;

    localparam int Q = 10;
    localparam logic [6:0] DEV = 7'h1D;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic       reg_re;
    logic       busy;

    int total = 0;
    int bad = 0;
    int re_cnt = 0;
    int both_cnt = 0;
    int dut_low_cnt = 0;

    logic [7:0]  mem [256];
    logic [7:0]  model_mem [256];
    logic [15:0] wlog [$];

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target dut (
        .clk        (clk),
        .rst        (rst),
        .GSENSOR_SCL(scl),
        .GSENSOR_SDA(sda),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    // Host register file plus bus monitors.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= model_mem[i];
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) wlog.push_back({reg_addr, reg_wdata});
        if (reg_re) re_cnt <= re_cnt + 1;
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
        if (sda === 1'b0 && !sda_low) dut_low_cnt <= dut_low_cnt + 1;
    end

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; hq();
        scl = 1'b1; hq();
        sda_low = 1'b1; hq();
        scl = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; hq();
        scl = 1'b1; hq();
        sda_low = 1'b0; hq();
        hq();
    endtask

    task automatic put_bit(input logic b);
        sda_low = ~b; hq();
        scl = 1'b1; hq();
        hq();
        scl = 1'b0; hq();
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; hq();
        scl = 1'b1; hq();
        b = sda; hq();
        scl = 1'b0; hq();
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack);
    endtask

    task automatic xfer_write(input logic [7:0] r, input logic [7:0] d[$],
                              output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        put_byte({DEV, 1'b0}, a); nacks += int'(a);
        put_byte(r, a); nacks += int'(a);
        foreach (d[i]) begin
            put_byte(d[i], a);
            nacks += int'(a);
        end
        i2c_stop();
    endtask

    task automatic xfer_read(input logic [7:0] r, input int n,
                             output logic [7:0] got[$], output int nacks);
        logic a;
        logic [7:0] v;
        nacks = 0;
        got.delete();
        i2c_start();
        put_byte({DEV, 1'b0}, a); nacks += int'(a);
        put_byte(r, a); nacks += int'(a);
        i2c_start();
        put_byte({DEV, 1'b1}, a); nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            get_byte(v, (i == n - 1));
            got.push_back(v);
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (sda !== 1'b1 || busy !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl sda=%b busy=%b we=%b re=%b exp 1000",
                     sda, busy, reg_we, reg_re);
        end
        total++;
        if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs addr=%h wdata=%h exp 00 00", reg_addr, reg_wdata);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        logic a;
        logic [7:0] bytes_q [3];
        bytes_q[0] = {DEV, 1'b0};
        bytes_q[1] = 8'hEE;
        bytes_q[2] = 8'hAB;
        wlog.delete();
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            put_byte(bytes_q[i], a);
            total++;
            if (a !== 1'b0) begin
                bad++;
                $display("FAIL wr_ack%0d got=%b exp=0", i, a);
            end
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_busy got=%b exp=1", busy);
                end
            end
        end
        i2c_stop();
        model_mem[8'hEE] = 8'hAB;
        total++;
        if (wlog.size() != 1) begin
            bad++;
            $display("FAIL wr_count got=%0d exp=1", wlog.size());
        end else begin
            total++;
            if (wlog[0] !== 16'hEEAB) begin
                bad++;
                $display("FAIL wr_data got=%h exp=eeab", wlog[0]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_busy_stop got=%b exp=0", busy);
        end
    endtask

    task automatic test_read_nack();
        logic a;
        logic [7:0] v;
        int re0;
        int low0;
        int nacks;
        nacks = 0;
        re0 = re_cnt;
        i2c_start();
        put_byte({DEV, 1'b0}, a); nacks += int'(a);
        put_byte(8'h00, a); nacks += int'(a);
        i2c_start();
        put_byte({DEV, 1'b1}, a); nacks += int'(a);
        get_byte(v, 1'b1);
        low0 = dut_low_cnt;
        total++;
        if (nacks != 0) begin
            bad++;
            $display("FAIL rd_acks nacked=%0d exp=0", nacks);
        end
        total++;
        if (v !== 8'hE5) begin
            bad++;
            $display("FAIL rd_byte got=%h exp=e5", v);
        end
        repeat (4 * Q) @(negedge clk);
        total++;
        if (busy !== 1'b1 || dut_low_cnt != low0) begin
            bad++;
            $display("FAIL rd_ignore busy=%b lows=%0d exp busy=1 lows=0",
                     busy, dut_low_cnt - low0);
        end
        i2c_stop();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_busy_stop got=%b exp=0", busy);
        end
        total++;
        if (re_cnt - re0 != 1) begin
            bad++;
            $display("FAIL rd_re_count got=%0d exp=1", re_cnt - re0);
        end
    endtask

    task automatic test_wrong_addr();
        logic a0;
        logic a1;
        int re0;
        int low0;
        re0 = re_cnt;
        low0 = dut_low_cnt;
        wlog.delete();
        i2c_start();
        put_byte({7'h53, 1'b0}, a0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL na_busy got=%b exp=0", busy);
        end
        put_byte(8'h12, a1);
        i2c_stop();
        total++;
        if (a0 !== 1'b1 || a1 !== 1'b1) begin
            bad++;
            $display("FAIL na_acks got=%b%b exp=11", a0, a1);
        end
        total++;
        if (dut_low_cnt != low0 || wlog.size() != 0 || re_cnt != re0) begin
            bad++;
            $display("FAIL na_quiet lows=%0d we=%0d re=%0d exp 0 0 0",
                     dut_low_cnt - low0, wlog.size(), re_cnt - re0);
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] d [$];
        logic [15:0] exp_q [$];
        int nacks;
        d = '{8'h10, 8'h20, 8'h30};
        exp_q = '{16'hFE10, 16'hFF20, 16'h0030};
        wlog.delete();
        xfer_write(8'hFE, d, nacks);
        model_mem[8'hFE] = 8'h10;
        model_mem[8'hFF] = 8'h20;
        model_mem[8'h00] = 8'h30;
        total++;
        if (nacks != 0 || wlog.size() != 3) begin
            bad++;
            $display("FAIL burst_count nacks=%0d we=%0d exp 0 3", nacks, wlog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wlog[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL burst_we%0d got=%h exp=%h", i, wlog[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stop_mid();
        logic a;
        int low0;
        i2c_start();
        put_byte({DEV, 1'b0}, a);
        put_byte(8'h42, a);
        wlog.delete();
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b1);
        i2c_stop();
        low0 = dut_low_cnt;
        repeat (2 * Q) @(negedge clk);
        total++;
        if (wlog.size() != 0) begin
            bad++;
            $display("FAIL mid_we got=%0d exp=0", wlog.size());
        end
        total++;
        if (busy !== 1'b0 || sda !== 1'b1 || dut_low_cnt != low0) begin
            bad++;
            $display("FAIL mid_idle busy=%b sda=%b exp busy=0 sda=1", busy, sda);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ad;
        ad = {DEV, 1'b0};
        i2c_start();
        for (int i = 7; i >= 0; i--) put_bit(ad[i]);
        sda_low = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sda !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre sda=%b busy=%b exp sda=0 busy=1", sda, busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (sda !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_sda got=%b exp=1", sda);
        end
        total++;
        if (busy !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0 ||
            reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_outs busy=%b we=%b re=%b addr=%h wdata=%h exp all 0",
                     busy, reg_we, reg_re, reg_addr, reg_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        hq();
        scl = 1'b1;
        hq();
    endtask

    task automatic test_random();
        logic [7:0] d [$];
        logic [7:0] got [$];
        logic [7:0] r;
        int n;
        int nacks;
        for (int it = 0; it < 8; it++) begin
            r = 8'($urandom);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                d.delete();
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
                wlog.delete();
                xfer_write(r, d, nacks);
                total++;
                if (nacks != 0 || wlog.size() != n) begin
                    bad++;
                    $display("FAIL rnd_wr%0d nacks=%0d we=%0d exp 0 %0d",
                             it, nacks, wlog.size(), n);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        total++;
                        if (wlog[i] !== {8'(r + i), d[i]}) begin
                            bad++;
                            $display("FAIL rnd_wr%0d_%0d got=%h exp=%h",
                                     it, i, wlog[i], {8'(r + i), d[i]});
                        end
                    end
                end
                for (int i = 0; i < n; i++) model_mem[8'(r + i)] = d[i];
            end else begin
                xfer_read(r, n, got, nacks);
                total++;
                if (nacks != 0) begin
                    bad++;
                    $display("FAIL rnd_rd%0d_ack nacked=%0d exp=0", it, nacks);
                end
                for (int i = 0; i < n; i++) begin
                    total++;
                    if (got[i] !== model_mem[8'(r + i)]) begin
                        bad++;
                        $display("FAIL rnd_rd%0d_%0d got=%h exp=%h",
                                 it, i, got[i], model_mem[8'(r + i)]);
                    end
                end
            end
        end
    endtask

    task automatic test_exclusive_strobes();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL we_re_overlap got=%0d exp=0", both_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
        model_mem[0] = 8'hE5;
        test_reset();
        test_write();
        test_read_nack();
        test_wrong_addr();
        test_burst_wrap();
        test_stop_mid();
        test_reset_mid();
        test_random();
        test_exclusive_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
